bsg_nasti_master_req_pipe: RTL and testbench
============================================

Name: bsg_nasti_master_req_pipe

Overview:
- Parametrised request-side NASTI (AXI4) master adapter for the FSB tunnel.
- Accepts one serialized request stream of write headers, read headers and write-data beats. Drives independent AR, AW and W channels.
- Differences from the single-transaction generation:
  - read headers are accepted while a write burst's data is still streaming;
  - up to max_wr_out_p writes may await B;
  - W LAST is generated from a beat counter;
  - protocol violations are flagged.

Parameters:
- addr_width_p, 32, AXI address width.
- data_width_p, 64, AXI data width; power of two, >= 8.
- id_width_p, 5, AXI ID width.
- burst_len_p, 8, beats per burst (1..256); drives AxLEN = burst_len_p-1.
- max_wr_out_p, 4, maximum writes issued on AW whose B has not yet returned (1..15).
- req_width_p, 65, request word width; must be >= max(1+id_width_p+addr_width_p, 1+data_width_p).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  request word valid
- req_data_i  in  req_width_p  request word. Header: [0]=rw (1=write), [id_width_p:1]=id, next addr_width_p bits=addr. Data beat: [0]=last, [data_width_p:1]=data.
- req_yumi_o  out  1  request word consumed this cycle
- nasti_ar_valid_o / nasti_ar_ready_i  out/in  1  AR handshake
- nasti_ar_id_o  out  id_width_p;  nasti_ar_addr_o  out  addr_width_p
- nasti_aw_valid_o / nasti_aw_ready_i  out/in  1  AW handshake
- nasti_aw_id_o  out  id_width_p;  nasti_aw_addr_o  out  addr_width_p
- nasti_ax_len_o  out  8  constant burst_len_p-1 (shared by AR/AW)
- nasti_ax_size_o  out  3  constant log2(data_width_p/8)
- nasti_ax_burst_o  out  2  constant 2'b01 (INCR)
- nasti_ax_cache_o  out  4  constant 4'd3; lock/prot/qos/region are tied to 0 at the top level
- nasti_w_valid_o / nasti_w_ready_i  out/in  1  W handshake
- nasti_w_data_o  out  data_width_p;  nasti_w_strb_o  out  data_width_p/8  all ones
- nasti_w_last_o  out  1  final beat of the burst
- nasti_b_valid_i  in  1;  nasti_b_resp_i  in  2;  nasti_b_ready_o  out  1  constant 1
- wr_out_cnt_o  out  4  writes awaiting B
- error_o  out  1  sticky protocol error

Behaviour:
- Reset (asynchronous, active-high): all valid outputs 0, req_yumi_o 0, wr_out_cnt_o 0, error_o 0, FSM in HDR, beat counter 0.
- Every output register is a 1-entry slot. The slot loads on a req_yumi_o into it and clears on its ready. Load and drain in the same cycle are allowed, giving full throughput.
- FSM, state HDR:
  - rw=0: yumi iff the AR slot is empty or draining this cycle. Load id/addr; AR valid the next cycle. Stay in HDR.
  - rw=1: yumi iff the AW slot is empty or draining, and (wr_out_cnt + AW slot occupancy) < max_wr_out_p. Load AW; go to DATA; beat counter cleared.
  - Otherwise no yumi (stall).
- FSM, state DATA:
  - Every word is a data beat. yumi iff the W slot is empty or draining; load data; increment the beat counter.
  - nasti_w_last_o = (beat index == burst_len_p-1), taken from the counter only.
  - Input last bit mismatches the counter-derived last: set error_o. Burst length is still governed by the counter.
  - Final beat accepted: go to HDR. A read header may be accepted the very next cycle.
- W may be presented before AW completes; W is not gated on AW (legal AXI).
- Outstanding-write counter:
  - +1 on AW fire, -1 on B fire; both in the same cycle leaves it unchanged.
  - B fire at count 0 sets error_o and the counter stays 0 (no underflow).
- AR and AW slots drain independently; no ordering is imposed between reads and writes.
- Latency: request word to channel valid is 1 cycle.

Optional Feature:
- Macro BSG_NASTI_MASTER_REQ_BRESP_CHECK_EN.
- Defined: a B fire with nasti_b_resp_i != 2'b00 (SLVERR/DECERR) sets error_o.
- Undefined: bresp is ignored; error_o reflects only beat-count mismatch and B underflow.

Test Plan:
- Read header id=3, addr=0x1000, ar_ready=1 -> AR valid 1 cycle later with id 3, addr 0x1000, len 7, size 3; req_yumi_o asserted in the header cycle.
- Write header plus 8 beats with data 0..7, w_ready always 1 -> W beats 0..7 back-to-back; last only on beat 7; AW fires once; wr_out_cnt_o goes to 1, then 0 after B.
- Five write bursts, no B returned, max_wr_out_p=4 -> fifth header stalls (yumi 0) until one B fires; fifth header accepted the cycle after the B.
- Input last on beat 5 of 8 -> error_o set and stays 1; W last still only on beat 7; a following read header is accepted normally.
- Write burst, then a read header immediately, ar_ready=0 for 10 cycles -> read header accepted; W traffic unaffected; AR fires when ready rises.
- Reset asserted mid-burst (beat 3) -> all valids drop to 0 asynchronously; after release, next word is treated as a header. With the macro defined, B with resp=2'b10 sets error_o.

Source files
------------

// File: rtl/bsg_nasti_master_req_pipe.sv
// Request-side NASTI master: splits one header/beat stream onto registered AR, AW and W slots.
// Optional BSG_NASTI_MASTER_REQ_BRESP_CHECK_EN flags non-OKAY write responses in error_o.
module bsg_nasti_master_req_pipe #(
   parameter int unsigned addr_width_p = 32,
   parameter int unsigned data_width_p = 64,
   parameter int unsigned id_width_p   = 5,
   parameter int unsigned burst_len_p  = 8,
   parameter int unsigned max_wr_out_p = 4,
   parameter int unsigned req_width_p  = 65
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      req_valid_i,
   input  logic [req_width_p-1:0]    req_data_i,
   output logic                      req_yumi_o,
   output logic                      nasti_ar_valid_o,
   input  logic                      nasti_ar_ready_i,
   output logic [id_width_p-1:0]     nasti_ar_id_o,
   output logic [addr_width_p-1:0]   nasti_ar_addr_o,
   output logic                      nasti_aw_valid_o,
   input  logic                      nasti_aw_ready_i,
   output logic [id_width_p-1:0]     nasti_aw_id_o,
   output logic [addr_width_p-1:0]   nasti_aw_addr_o,
   output logic [7:0]                nasti_ax_len_o,
   output logic [2:0]                nasti_ax_size_o,
   output logic [1:0]                nasti_ax_burst_o,
   output logic [3:0]                nasti_ax_cache_o,
   output logic                      nasti_w_valid_o,
   input  logic                      nasti_w_ready_i,
   output logic [data_width_p-1:0]   nasti_w_data_o,
   output logic [data_width_p/8-1:0] nasti_w_strb_o,
   output logic                      nasti_w_last_o,
   input  logic                      nasti_b_valid_i,
   input  logic [1:0]                nasti_b_resp_i,
   output logic                      nasti_b_ready_o,
   output logic [3:0]                wr_out_cnt_o,
   output logic                      error_o
);

   localparam int unsigned strb_width_lp = data_width_p / 8;
   localparam logic [7:0]  last_idx_lp   = 8'(burst_len_p - 1);

   typedef enum logic {e_hdr, e_data} state_e;

   state_e                  state_r;
   logic [7:0]              beat_r;
   logic [3:0]              wr_out_r;
   logic                    ar_v_r, aw_v_r, w_v_r, w_last_r, error_r;
   logic [id_width_p-1:0]   ar_id_r, aw_id_r;
   logic [addr_width_p-1:0] ar_addr_r, aw_addr_r;
   logic [data_width_p-1:0] w_data_r;

   logic                    hdr_rw, beat_last_in, beat_last;
   logic [id_width_p-1:0]   hdr_id;
   logic [addr_width_p-1:0] hdr_addr;
   logic                    ar_fire, aw_fire, w_fire, b_fire;
   logic                    ar_free, aw_free, w_free, wr_room;
   logic                    yumi_c, rd_hdr_acc, wr_hdr_acc, beat_acc, bresp_err;

   assign hdr_rw       = req_data_i[0];
   assign beat_last_in = req_data_i[0];
   assign hdr_id       = req_data_i[id_width_p:1];
   assign hdr_addr     = req_data_i[id_width_p+addr_width_p:id_width_p+1];
   assign beat_last    = (beat_r == last_idx_lp);

   assign ar_fire = ar_v_r & nasti_ar_ready_i;
   assign aw_fire = aw_v_r & nasti_aw_ready_i;
   assign w_fire  = w_v_r  & nasti_w_ready_i;
   assign b_fire  = nasti_b_valid_i;

   assign ar_free = ~ar_v_r | nasti_ar_ready_i;
   assign aw_free = ~aw_v_r | nasti_aw_ready_i;
   assign w_free  = ~w_v_r  | nasti_w_ready_i;
   // A write still sitting in the AW slot counts toward the outstanding limit.
   assign wr_room = ({1'b0, wr_out_r} + 5'(aw_v_r)) < 5'(max_wr_out_p);

`ifdef BSG_NASTI_MASTER_REQ_BRESP_CHECK_EN
   assign bresp_err = b_fire & (nasti_b_resp_i != 2'b00);
`else
   // Response code is ignored; x & ~x keeps the port read while evaluating to 0.
   assign bresp_err = b_fire & (&{nasti_b_resp_i, ~nasti_b_resp_i});
`endif

   always_comb begin
      yumi_c = 1'b0;
      if (req_valid_i && !reset_i) begin
         if (state_r == e_data) yumi_c = w_free;
         else if (hdr_rw)       yumi_c = aw_free & wr_room;
         else                   yumi_c = ar_free;
      end
   end

   assign rd_hdr_acc = yumi_c & (state_r == e_hdr) & ~hdr_rw;
   assign wr_hdr_acc = yumi_c & (state_r == e_hdr) &  hdr_rw;
   assign beat_acc   = yumi_c & (state_r == e_data);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r   <= e_hdr;
         beat_r    <= '0;
         wr_out_r  <= '0;
         ar_v_r    <= 1'b0;
         aw_v_r    <= 1'b0;
         w_v_r     <= 1'b0;
         w_last_r  <= 1'b0;
         error_r   <= 1'b0;
         ar_id_r   <= '0;
         aw_id_r   <= '0;
         ar_addr_r <= '0;
         aw_addr_r <= '0;
         w_data_r  <= '0;
      end else begin
         if (ar_fire) ar_v_r <= 1'b0;
         if (rd_hdr_acc) begin
            ar_v_r    <= 1'b1;
            ar_id_r   <= hdr_id;
            ar_addr_r <= hdr_addr;
         end
         if (aw_fire) aw_v_r <= 1'b0;
         if (wr_hdr_acc) begin
            aw_v_r    <= 1'b1;
            aw_id_r   <= hdr_id;
            aw_addr_r <= hdr_addr;
            state_r   <= e_data;
            beat_r    <= '0;
         end
         if (w_fire) w_v_r <= 1'b0;
         // Burst length follows the counter; the input last bit is only cross-checked.
         if (beat_acc) begin
            w_v_r    <= 1'b1;
            w_data_r <= req_data_i[data_width_p:1];
            w_last_r <= beat_last;
            beat_r   <= beat_r + 8'd1;
            if (beat_last) state_r <= e_hdr;
         end
         if (aw_fire && !b_fire)
            wr_out_r <= wr_out_r + 4'd1;
         else if (b_fire && !aw_fire && wr_out_r != 4'd0)
            wr_out_r <= wr_out_r - 4'd1;
         if ((beat_acc && (beat_last_in != beat_last)) ||
             (b_fire && wr_out_r == 4'd0) || bresp_err)
            error_r <= 1'b1;
      end
   end

   assign req_yumi_o       = yumi_c;
   assign nasti_ar_valid_o = ar_v_r;
   assign nasti_ar_id_o    = ar_id_r;
   assign nasti_ar_addr_o  = ar_addr_r;
   assign nasti_aw_valid_o = aw_v_r;
   assign nasti_aw_id_o    = aw_id_r;
   assign nasti_aw_addr_o  = aw_addr_r;
   assign nasti_ax_len_o   = last_idx_lp;
   assign nasti_ax_size_o  = 3'($clog2(strb_width_lp));
   assign nasti_ax_burst_o = 2'b01;
   assign nasti_ax_cache_o = 4'd3;
   assign nasti_w_valid_o  = w_v_r;
   assign nasti_w_data_o   = w_data_r;
   assign nasti_w_strb_o   = '1;
   assign nasti_w_last_o   = w_last_r;
   assign nasti_b_ready_o  = 1'b1;
   assign wr_out_cnt_o     = wr_out_r;
   assign error_o          = error_r;

endmodule

// File: tb/tb_bsg_nasti_master_req_pipe.sv
// Bench for bsg_nasti_master_req_pipe: directed scenarios plus randomized traffic against queue-based expectations.
module tb_bsg_nasti_master_req_pipe;
   localparam int unsigned AW = 32, DW = 64, IW = 5, BL = 8, MO = 4, RW = 65;

   logic clk_i = 1'b0;
   logic reset_i;
   logic req_valid_i, req_yumi_o;
   logic [RW-1:0] req_data_i;
   logic ar_valid, ar_ready, aw_valid, aw_ready, w_valid, w_ready, w_last;
   logic [IW-1:0] ar_id, aw_id;
   logic [AW-1:0] ar_addr, aw_addr;
   logic [7:0] ax_len; logic [2:0] ax_size; logic [1:0] ax_burst; logic [3:0] ax_cache;
   logic [DW-1:0] w_data; logic [DW/8-1:0] w_strb;
   logic b_valid, b_ready; logic [1:0] b_resp;
   logic [3:0] wr_out_cnt; logic error;

   logic dir_ar_ready, dir_aw_ready, dir_w_ready, dir_b_valid; logic [1:0] dir_b_resp;
   logic rnd_ar_ready, rnd_aw_ready, rnd_w_ready, rnd_b_valid, rnd_en;
   assign ar_ready = rnd_en ? rnd_ar_ready : dir_ar_ready;
   assign aw_ready = rnd_en ? rnd_aw_ready : dir_aw_ready;
   assign w_ready  = rnd_en ? rnd_w_ready  : dir_w_ready;
   assign b_valid  = rnd_en ? rnd_b_valid  : dir_b_valid;
   assign b_resp   = rnd_en ? 2'b00        : dir_b_resp;

   int vectors = 0, miscompares = 0;
   logic [IW+AW-1:0] act_ar[$], act_aw[$], exp_ar[$], exp_aw[$];
   logic [DW:0] act_w[$], exp_w[$];
   int model_out = 0;

   bsg_nasti_master_req_pipe #(.addr_width_p(AW), .data_width_p(DW), .id_width_p(IW),
      .burst_len_p(BL), .max_wr_out_p(MO), .req_width_p(RW)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
      .req_yumi_o(req_yumi_o), .nasti_ar_valid_o(ar_valid), .nasti_ar_ready_i(ar_ready),
      .nasti_ar_id_o(ar_id), .nasti_ar_addr_o(ar_addr), .nasti_aw_valid_o(aw_valid),
      .nasti_aw_ready_i(aw_ready), .nasti_aw_id_o(aw_id), .nasti_aw_addr_o(aw_addr),
      .nasti_ax_len_o(ax_len), .nasti_ax_size_o(ax_size), .nasti_ax_burst_o(ax_burst),
      .nasti_ax_cache_o(ax_cache), .nasti_w_valid_o(w_valid), .nasti_w_ready_i(w_ready),
      .nasti_w_data_o(w_data), .nasti_w_strb_o(w_strb), .nasti_w_last_o(w_last),
      .nasti_b_valid_i(b_valid), .nasti_b_resp_i(b_resp), .nasti_b_ready_o(b_ready),
      .wr_out_cnt_o(wr_out_cnt), .error_o(error));

   always #5 clk_i = ~clk_i;

   // Channel monitor: records every handshake and tracks writes awaiting B.
   always @(posedge clk_i or posedge reset_i) begin
      if (reset_i) model_out = 0;
      else begin
         if (ar_valid && ar_ready) act_ar.push_back({ar_id, ar_addr});
         if (aw_valid && aw_ready) begin act_aw.push_back({aw_id, aw_addr}); model_out++; end
         if (w_valid && w_ready) act_w.push_back({w_last, w_data});
         if (b_valid && b_ready && model_out > 0) model_out--;
      end
   end

   always @(posedge clk_i) begin
      #1;
      rnd_ar_ready = ($urandom_range(0, 3) != 0);
      rnd_aw_ready = ($urandom_range(0, 2) != 0);
      rnd_w_ready  = ($urandom_range(0, 3) != 0);
      rnd_b_valid  = (model_out > 0) && ($urandom_range(0, 2) == 0);
   end

   always @(negedge clk_i) begin
      if (rnd_en && !reset_i) begin
         vectors++;
         if (wr_out_cnt !== 4'(model_out) || model_out > int'(MO)) begin
            miscompares++;
            $display("FAIL rnd_wr_out_cnt: got %0d want %0d (limit %0d)", wr_out_cnt, model_out, MO);
         end
      end
   end

   function automatic logic [RW-1:0] hdr(input logic rw, input logic [IW-1:0] id, input logic [AW-1:0] addr);
      logic [RW-1:0] w;
      w = '0; w[0] = rw; w[IW:1] = id; w[IW+AW:IW+1] = addr;
      return w;
   endfunction

   function automatic logic [RW-1:0] beat(input logic [DW-1:0] d, input logic last);
      return RW'({d, last});
   endfunction

   task automatic tick(); @(posedge clk_i); #1; endtask

   task automatic send(input logic [RW-1:0] w, output int waited);
      waited = 0;
      req_valid_i = 1'b1; req_data_i = w;
      @(negedge clk_i);
      while (!req_yumi_o && waited < 300) begin @(negedge clk_i); waited++; end
      if (!req_yumi_o) begin
         vectors++; miscompares++;
         $display("FAIL send_timeout: yumi=%b after %0d cycles, want 1", req_yumi_o, waited);
      end
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
   endtask

   task automatic send_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input logic [DW-1:0] base, input int last_pos, output int wsum);
      int w;
      send(hdr(1'b1, id, addr), w); wsum = w;
      exp_aw.push_back({id, addr});
      for (int i = 0; i < int'(BL); i++) begin
         send(beat(base + DW'(i), i == last_pos), w); wsum += w;
         exp_w.push_back({i == int'(BL) - 1, base + DW'(i)});
      end
   endtask

   task automatic b_pulse(input logic [1:0] resp);
      dir_b_valid = 1'b1; dir_b_resp = resp;
      tick();
      dir_b_valid = 1'b0; dir_b_resp = 2'b00;
   endtask

   task automatic do_reset();
      reset_i = 1'b1; tick(); tick(); reset_i = 1'b0; tick();
   endtask

   task automatic test_reset();
      reset_i = 1'b1; req_valid_i = 1'b1; req_data_i = hdr(1'b0, 5'd1, 32'h0);
      #3;
      vectors++;
      if ({ar_valid, aw_valid, w_valid, req_yumi_o, error, wr_out_cnt} !== 9'b0) begin
         miscompares++;
         $display("FAIL reset_state: ar/aw/w/yumi/err/cnt=%b%b%b%b%b/%0d want all 0",
                  ar_valid, aw_valid, w_valid, req_yumi_o, error, wr_out_cnt);
      end
      vectors++;
      if (ax_len !== 8'd7 || ax_size !== 3'd3 || ax_burst !== 2'b01 || ax_cache !== 4'd3 ||
          w_strb !== 8'hff || b_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL constants: len=%0d size=%0d burst=%0d cache=%0d strb=%h bready=%b want 7 3 1 3 ff 1",
                  ax_len, ax_size, ax_burst, ax_cache, w_strb, b_ready);
      end
      tick(); tick();
      req_valid_i = 1'b0; reset_i = 1'b0;
      tick();
   endtask

   task automatic test_read();
      int w;
      dir_ar_ready = 1'b1; act_ar.delete();
      send(hdr(1'b0, 5'd3, 32'h1000), w);
      vectors++;
      if (w !== 0 || ar_valid !== 1'b1 || ar_id !== 5'd3 || ar_addr !== 32'h1000) begin
         miscompares++;
         $display("FAIL read_hdr: wait=%0d valid=%b id=%0d addr=%h want 0 1 3 00001000", w, ar_valid, ar_id, ar_addr);
      end
      tick();
      vectors++;
      if (act_ar.size() != 1 || ar_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL read_fire: fires=%0d valid=%b want 1 0", act_ar.size(), ar_valid);
      end
   endtask

   task automatic test_write_burst();
      int ws;
      dir_aw_ready = 1'b1; dir_w_ready = 1'b1; act_aw.delete(); act_w.delete();
      send_burst(5'd5, 32'h2000, 64'd0, BL - 1, ws);
      tick();
      vectors++;
      if (ws !== 0 || act_w.size() != int'(BL)) begin
         miscompares++;
         $display("FAIL wr_beats: stalls=%0d beats=%0d want 0 %0d", ws, act_w.size(), BL);
      end
      for (int i = 0; i < act_w.size(); i++) begin
         vectors++;
         if (act_w[i] !== {i == int'(BL) - 1, DW'(i)}) begin
            miscompares++;
            $display("FAIL wr_beat%0d: got %h want %h", i, act_w[i], {i == int'(BL) - 1, DW'(i)});
         end
      end
      vectors++;
      if (act_aw.size() != 1 || wr_out_cnt !== 4'd1) begin
         miscompares++;
         $display("FAIL wr_aw: aw_fires=%0d cnt=%0d want 1 1", act_aw.size(), wr_out_cnt);
      end
      b_pulse(2'b00);
      vectors++;
      if (wr_out_cnt !== 4'd0 || error !== 1'b0) begin
         miscompares++;
         $display("FAIL wr_b: cnt=%0d err=%b want 0 0", wr_out_cnt, error);
      end
   endtask

   task automatic test_max_outstanding();
      int ws, w;
      logic saw_yumi;
      for (int b = 0; b < 4; b++) send_burst(5'(b), 32'(b * 'h100), 64'(b * 16), BL - 1, ws);
      tick();
      vectors++;
      if (wr_out_cnt !== 4'd4) begin
         miscompares++; $display("FAIL max_cnt: got %0d want 4", wr_out_cnt);
      end
      req_valid_i = 1'b1; req_data_i = hdr(1'b1, 5'd7, 32'h3000);
      saw_yumi = 1'b0;
      repeat (6) begin @(negedge clk_i); saw_yumi |= req_yumi_o; end
      @(posedge clk_i); #1; dir_b_valid = 1'b1;
      @(negedge clk_i); saw_yumi |= req_yumi_o;
      vectors++;
      if (saw_yumi !== 1'b0) begin
         miscompares++; $display("FAIL max_stall: yumi seen=%b want 0", saw_yumi);
      end
      @(posedge clk_i); #1; dir_b_valid = 1'b0;
      @(negedge clk_i);
      vectors++;
      if (req_yumi_o !== 1'b1) begin
         miscompares++; $display("FAIL max_release: yumi=%b want 1", req_yumi_o);
      end
      @(posedge clk_i); #1; req_valid_i = 1'b0;
      for (int i = 0; i < int'(BL); i++) send(beat(64'(100 + i), i == int'(BL) - 1), w);
      tick();
      repeat (4) b_pulse(2'b00);
      vectors++;
      if (wr_out_cnt !== 4'd0 || error !== 1'b0) begin
         miscompares++; $display("FAIL max_drain: cnt=%0d err=%b want 0 0", wr_out_cnt, error);
      end
   endtask

   task automatic test_last_mismatch();
      int ws, w, nlast;
      act_w.delete(); act_ar.delete();
      send_burst(5'd2, 32'h4400, 64'd32, 5, ws);
      tick();
      nlast = 0;
      foreach (act_w[i]) nlast += int'(act_w[i][DW]);
      vectors++;
      if (error !== 1'b1 || act_w.size() != int'(BL) || nlast != 1 || act_w[BL-1][DW] !== 1'b1) begin
         miscompares++;
         $display("FAIL last_mismatch: err=%b beats=%0d lasts=%0d want 1 %0d 1 (on beat 7)",
                  error, act_w.size(), nlast, BL);
      end
      send(hdr(1'b0, 5'd8, 32'h8800), w);
      tick();
      vectors++;
      if (w !== 0 || act_ar.size() != 1 || act_ar[0] !== {5'd8, 32'h8800} || error !== 1'b1) begin
         miscompares++;
         $display("FAIL last_then_read: wait=%0d ar_fires=%0d err=%b want 0 1 1", w, act_ar.size(), error);
      end
      b_pulse(2'b00);
   endtask

   task automatic test_ar_stall();
      int ws, w;
      logic bad;
      dir_ar_ready = 1'b0; act_ar.delete(); act_w.delete();
      send_burst(5'd4, 32'h4000, 64'd200, BL - 1, ws);
      send(hdr(1'b0, 5'd9, 32'h5000), w);
      tick();
      vectors++;
      if (w !== 0 || act_w.size() != int'(BL)) begin
         miscompares++; $display("FAIL ar_stall_accept: wait=%0d beats=%0d want 0 %0d", w, act_w.size(), BL);
      end
      bad = 1'b0;
      repeat (10) begin tick(); if (ar_valid !== 1'b1 || act_ar.size() != 0) bad = 1'b1; end
      vectors++;
      if (bad !== 1'b0) begin
         miscompares++; $display("FAIL ar_stall_hold: bad=%b want 0", bad);
      end
      dir_ar_ready = 1'b1; tick();
      vectors++;
      if (act_ar.size() != 1 || act_ar[0] !== {5'd9, 32'h5000}) begin
         miscompares++; $display("FAIL ar_stall_fire: fires=%0d want 1 with id 9 addr 5000", act_ar.size());
      end
      b_pulse(2'b00);
   endtask

   task automatic test_underflow();
      do_reset();
      b_pulse(2'b00);
      vectors++;
      if (error !== 1'b1 || wr_out_cnt !== 4'd0) begin
         miscompares++; $display("FAIL b_underflow: err=%b cnt=%0d want 1 0", error, wr_out_cnt);
      end
   endtask

   task automatic test_reset_mid_burst();
      int w, ws;
      do_reset();
      dir_aw_ready = 1'b1; dir_w_ready = 1'b1; dir_ar_ready = 1'b1;
      send(hdr(1'b1, 5'd6, 32'h6000), w);
      for (int i = 0; i < 3; i++) send(beat(64'(i), 1'b0), w);
      dir_w_ready = 1'b0;
      req_valid_i = 1'b1; req_data_i = beat(64'd3, 1'b0);
      #2 reset_i = 1'b1;
      #1;
      vectors++;
      if ({ar_valid, aw_valid, w_valid, req_yumi_o, error, wr_out_cnt} !== 9'b0) begin
         miscompares++;
         $display("FAIL reset_mid: ar/aw/w/yumi/err/cnt=%b%b%b%b%b/%0d want all 0",
                  ar_valid, aw_valid, w_valid, req_yumi_o, error, wr_out_cnt);
      end
      req_valid_i = 1'b0;
      @(posedge clk_i); #1; reset_i = 1'b0; dir_w_ready = 1'b1; act_ar.delete(); act_aw.delete();
      send(hdr(1'b0, 5'd11, 32'h7000), w);
      tick();
      vectors++;
      if (act_ar.size() != 1 || act_ar[0] !== {5'd11, 32'h7000} || act_aw.size() != 0) begin
         miscompares++;
         $display("FAIL reset_then_hdr: ar_fires=%0d aw_fires=%0d want 1 0", act_ar.size(), act_aw.size());
      end
      send_burst(5'd12, 32'h7100, 64'd0, BL - 1, ws);
      tick();
      b_pulse(2'b10);
      vectors++;
`ifdef BSG_NASTI_MASTER_REQ_BRESP_CHECK_EN
      if (error !== 1'b1) begin
         miscompares++; $display("FAIL bresp_slverr: err=%b want 1", error);
      end
`else
      if (error !== 1'b0) begin
         miscompares++; $display("FAIL bresp_ignored: err=%b want 0", error);
      end
`endif
   endtask

   task automatic test_random();
      int w, ws;
      logic done;
      logic [IW-1:0] id; logic [AW-1:0] addr;
      do_reset();
      act_ar.delete(); act_aw.delete(); act_w.delete();
      exp_ar.delete(); exp_aw.delete(); exp_w.delete();
      rnd_en = 1'b1;
      for (int n = 0; n < 30; n++) begin
         id = IW'($urandom); addr = $urandom;
         if ($urandom_range(0, 1) == 0) begin
            exp_ar.push_back({id, addr});
            send(hdr(1'b0, id, addr), w);
         end else begin
            send_burst(id, addr, {$urandom, $urandom}, BL - 1, ws);
         end
      end
      done = 1'b0;
      for (int c = 0; c < 2000 && !done; c++) begin
         tick();
         done = (act_ar.size() == exp_ar.size()) && (act_aw.size() == exp_aw.size()) &&
                (act_w.size() == exp_w.size()) && model_out == 0 && !ar_valid && !aw_valid && !w_valid;
      end
      rnd_en = 1'b0;
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL rnd_drain: ar %0d/%0d aw %0d/%0d w %0d/%0d out=%0d",
                  act_ar.size(), exp_ar.size(), act_aw.size(), exp_aw.size(), act_w.size(), exp_w.size(), model_out);
      end
      foreach (exp_ar[i]) begin
         vectors++;
         if (i >= act_ar.size() || act_ar[i] !== exp_ar[i]) begin
            miscompares++; $display("FAIL rnd_ar%0d: got %h want %h", i, (i < act_ar.size()) ? act_ar[i] : '0, exp_ar[i]);
         end
      end
      foreach (exp_aw[i]) begin
         vectors++;
         if (i >= act_aw.size() || act_aw[i] !== exp_aw[i]) begin
            miscompares++; $display("FAIL rnd_aw%0d: got %h want %h", i, (i < act_aw.size()) ? act_aw[i] : '0, exp_aw[i]);
         end
      end
      foreach (exp_w[i]) begin
         vectors++;
         if (i >= act_w.size() || act_w[i] !== exp_w[i]) begin
            miscompares++; $display("FAIL rnd_w%0d: got %h want %h", i, (i < act_w.size()) ? act_w[i] : '0, exp_w[i]);
         end
      end
      vectors++;
      if (error !== 1'b0) begin
         miscompares++; $display("FAIL rnd_error: err=%b want 0", error);
      end
   endtask

   initial begin
      rnd_en = 1'b0; dir_ar_ready = 1'b0; dir_aw_ready = 1'b0; dir_w_ready = 1'b0;
      dir_b_valid = 1'b0; dir_b_resp = 2'b00; req_valid_i = 1'b0; req_data_i = '0;
      test_reset();
      test_read();
      test_write_burst();
      test_max_outstanding();
      test_last_mismatch();
      test_ar_stall();
      test_underflow();
      test_reset_mid_burst();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
